// File: rtl/instr_fetch_unit_pkg.sv
// Shared parameters, state encoding and opcode helper for the instruction fetch stage.
package instr_fetch_unit_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 60;
  localparam int OPC_W  = 4;
  localparam int CNT_W  = 16;

  localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [OPC_W-1:0] opcodeOf(input logic [DATA_W-1:0] word);
    return word[DATA_W-1 -: OPC_W];
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the fetch stage's control, memory and decode-handshake signals.
interface instr_fetch_unit_if;
  import instr_fetch_unit_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              dec_ready;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  retired_cnt;

  modport master (
    input  start, start_pc, br_valid, br_target, imem_rdata, dec_ready,
    output imem_addr, instr, instr_pc, instr_valid, busy, done, retired_cnt
  );

  modport slave (
    output start, start_pc, br_valid, br_target, imem_rdata, dec_ready,
    input  imem_addr, instr, instr_pc, instr_valid, busy, done, retired_cnt
  );

endinterface

// File: rtl/instr_fetch_unit.sv
// Program-counter / fetch stage in front of a 1-cycle synchronous instruction memory,
// with start/halt sequencing, branch squash, decode back-pressure and a retire counter.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              running;
  logic              valid;
  logic              accept;
  logic              isHalt;

  assign running = (state_q == RUN);
  assign valid   = running && !bus.br_valid;
  assign accept  = valid && bus.dec_ready;
  assign isHalt  = (opcodeOf(bus.imem_rdata) == HALT_OPC);

  // pc_d is the address presented to memory now; the word comes back next cycle,
  // so re-presenting pc_q during a stall keeps the shown instruction stable.
  always_comb begin
    pc_d = bus.start_pc;
    if (running) begin
      if (bus.br_valid)
        pc_d = bus.br_target;
      else if (valid && !bus.dec_ready)
        pc_d = pc_q;
      else
        pc_d = pc_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= RUN;
            pc_q    <= bus.start_pc;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          pc_q <= pc_d;
          if (accept) begin
            if (cnt_q != '1)
              cnt_q <= cnt_q + CNT_W'(1);
            if (isHalt)
              state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.imem_addr   = pc_d;
  assign bus.instr       = bus.imem_rdata;
  assign bus.instr_pc    = pc_q;
  assign bus.instr_valid = valid;
  assign bus.busy        = running;
  assign bus.done        = (state_q == DONE);
  assign bus.retired_cnt = cnt_q;

endmodule
